// File: rtl/b_predictor_assoc_pkg.sv
// Shared types and helpers for the branch predictor: BTB entry layout, 2-bit counter states,
// saturating counter arithmetic and the local-history shift.
package bp_pkg;

    localparam int HIST_MAX = 32;
    localparam int TAG_MAX  = 30;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // Tags are stored zero-extended to the widest possible tag so one entry type fits every geometry.
    typedef struct packed {
        logic               valid;
        logic [TAG_MAX-1:0] tag;
        logic [31:0]        target;
    } btb_entry_t;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == ST) ? ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == SNT) ? SNT : c - 2'd1;
    endfunction

    function automatic logic [HIST_MAX-1:0] hist_shift(input logic [HIST_MAX-1:0] h, input logic b);
        return {h[HIST_MAX-2:0], b};
    endfunction

endpackage

// File: rtl/b_predictor_assoc_lru_set.sv
// True-LRU age vector for one BTB set; victim_way is the way holding the oldest age.
// Latency: victim is combinational from state, touch lands next edge. No backpressure.
module bp_lru_set #(
    parameter  int WAYS  = 4,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             touch_en,
    input  logic [WAY_W-1:0] touch_way,
    output logic [WAY_W-1:0] victim_way
);

    logic [WAY_W-1:0] age [WAYS];

    // Ages form a permutation of 0..WAYS-1; a touch rotates younger ways up by one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int w = 0; w < WAYS; w++) age[w] <= WAY_W'(w);
        end else if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == touch_way)
                    age[w] <= '0;
                else if (age[w] < age[touch_way])
                    age[w] <= age[w] + WAY_W'(1);
            end
        end
    end

    always_comb begin
        victim_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (age[w] == WAY_W'(WAYS - 1)) victim_way = WAY_W'(w);
    end

endmodule

// File: rtl/b_predictor_assoc.sv
// Local-history direction predictor + set-associative true-LRU BTB; optional counters via B_PREDICTOR_STATS_EN.
// Latency: prediction is combinational on pred_pc; commit training and history repair land next edge.
// Backpressure: none, accepts a prediction lookup and a commit every cycle.
module b_predictor_assoc
    import bp_pkg::*;
#(
    parameter int LHT_ENTRIES = 64,
    parameter int HIST_W      = 4,
    parameter int PHT_XOR     = 0,
    parameter int BTB_SETS    = 16,
    parameter int BTB_WAYS    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pred_valid,
    input  logic [31:0] pred_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        commit_taken,
    input  logic [31:0] commit_target,
    input  logic        commit_mispredict
`ifdef B_PREDICTOR_STATS_EN
    ,
    output logic [31:0] stat_commits,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int LHT_W = $clog2(LHT_ENTRIES);
    localparam int SET_W = $clog2(BTB_SETS);
    localparam int WAY_W = $clog2(BTB_WAYS);
    localparam int TAG_W = 30 - SET_W;
    localparam int PHT_N = 1 << HIST_W;

    logic [HIST_W-1:0] spec_hist [LHT_ENTRIES];
    logic [HIST_W-1:0] comm_hist [LHT_ENTRIES];
    logic [1:0]        pht       [PHT_N];
    btb_entry_t        btb       [BTB_SETS][BTB_WAYS];

    function automatic logic [HIST_W-1:0] pht_idx(input logic [HIST_W-1:0] h, input logic [HIST_W-1:0] pc_bits);
        return (PHT_XOR != 0) ? (h ^ pc_bits) : h;
    endfunction

    // Prediction side
    logic [LHT_W-1:0]   p_lht;
    logic [SET_W-1:0]   p_set;
    logic [TAG_MAX-1:0] p_tag;
    logic [HIST_W-1:0]  p_hist;
    logic               p_hit;
    logic [WAY_W-1:0]   p_way;
    logic [31:0]        p_tgt;

    assign p_lht  = pred_pc[2 +: LHT_W];
    assign p_set  = pred_pc[2 +: SET_W];
    assign p_tag  = TAG_MAX'(pred_pc[31 -: TAG_W]);
    assign p_hist = spec_hist[p_lht];

    always_comb begin
        p_hit = 1'b0;
        p_way = '0;
        p_tgt = '0;
        for (int w = 0; w < BTB_WAYS; w++) begin
            if (!p_hit && btb[p_set][w].valid && btb[p_set][w].tag == p_tag) begin
                p_hit = 1'b1;
                p_way = WAY_W'(w);
                p_tgt = btb[p_set][w].target;
            end
        end
    end

    assign pred_hit    = p_hit;
    assign pred_taken  = p_hit & pht[pht_idx(p_hist, pred_pc[2 +: HIST_W])][1];
    assign pred_target = p_tgt;

    // Commit side
    logic [LHT_W-1:0]   c_lht;
    logic [SET_W-1:0]   c_set;
    logic [TAG_MAX-1:0] c_tag;
    logic [HIST_W-1:0]  c_hist;
    logic [HIST_W-1:0]  c_hist_nxt;
    logic [HIST_W-1:0]  c_pidx;
    logic               c_hit;
    logic [WAY_W-1:0]   c_hit_way;
    logic               c_free;
    logic [WAY_W-1:0]   c_free_way;
    logic [WAY_W-1:0]   c_way;
    logic               c_btb_wr;
    logic [WAY_W-1:0]   lru_victim [BTB_SETS];

    assign c_lht      = commit_pc[2 +: LHT_W];
    assign c_set      = commit_pc[2 +: SET_W];
    assign c_tag      = TAG_MAX'(commit_pc[31 -: TAG_W]);
    assign c_hist     = comm_hist[c_lht];
    assign c_hist_nxt = HIST_W'(hist_shift(HIST_MAX'(c_hist), commit_taken));
    assign c_pidx     = pht_idx(c_hist, commit_pc[2 +: HIST_W]);
    assign c_btb_wr   = commit_valid & commit_taken;

    always_comb begin
        c_hit      = 1'b0;
        c_hit_way  = '0;
        c_free     = 1'b0;
        c_free_way = '0;
        for (int w = 0; w < BTB_WAYS; w++) begin
            if (!c_hit && btb[c_set][w].valid && btb[c_set][w].tag == c_tag) begin
                c_hit     = 1'b1;
                c_hit_way = WAY_W'(w);
            end
        end
        for (int w = BTB_WAYS - 1; w >= 0; w--) begin
            if (!btb[c_set][w].valid) begin
                c_free     = 1'b1;
                c_free_way = WAY_W'(w);
            end
        end
    end

    assign c_way = c_hit ? c_hit_way : (c_free ? c_free_way : lru_victim[c_set]);

    // Commit touch owns the set's LRU for the cycle; a same-set pred touch is dropped.
    for (genvar s = 0; s < BTB_SETS; s++) begin : g_lru
        logic c_touch;
        logic p_touch;
        assign c_touch = c_btb_wr && (c_set == SET_W'(s));
        assign p_touch = pred_valid && p_hit && (p_set == SET_W'(s));

        bp_lru_set #(.WAYS(BTB_WAYS)) u_lru (
            .clk        (clk),
            .rst        (rst),
            .touch_en   (c_touch | p_touch),
            .touch_way  (c_touch ? c_way : p_way),
            .victim_way (lru_victim[s])
        );
    end

    // Repair copies the committed table including this cycle's commit shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LHT_ENTRIES; i++) begin
                spec_hist[i] <= '0;
                comm_hist[i] <= '0;
            end
        end else begin
            if (commit_valid)
                comm_hist[c_lht] <= c_hist_nxt;
            if (commit_valid && commit_mispredict) begin
                for (int i = 0; i < LHT_ENTRIES; i++)
                    spec_hist[i] <= (LHT_W'(i) == c_lht) ? c_hist_nxt : comm_hist[i];
            end else if (pred_valid && p_hit) begin
                spec_hist[p_lht] <= HIST_W'(hist_shift(HIST_MAX'(p_hist), pred_taken));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PHT_N; i++) pht[i] <= WNT;
        end else if (commit_valid) begin
            pht[c_pidx] <= commit_taken ? sat_inc(pht[c_pidx]) : sat_dec(pht[c_pidx]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < BTB_SETS; s++)
                for (int w = 0; w < BTB_WAYS; w++)
                    btb[s][w] <= '0;
        end else if (c_btb_wr) begin
            btb[c_set][c_way] <= '{valid: 1'b1, tag: c_tag, target: commit_target};
        end
    end

`ifdef B_PREDICTOR_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_commits     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (commit_valid)
                stat_commits <= stat_commits + 32'd1;
            if (commit_valid && commit_mispredict)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[1:0], commit_pc[1:0]};

endmodule

// File: tb/tb_b_predictor_assoc.sv
// Bench for b_predictor_assoc: directed scenarios plus random traffic against a recency-list reference model.
// Expected predictions are queued at issue time and checked by an independent negedge monitor.
module tb_b_predictor_assoc;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_taken;
    logic [31:0] commit_target;
    logic        commit_mispredict;
`ifdef B_PREDICTOR_STATS_EN
    logic [31:0] stat_commits;
    logic [31:0] stat_mispredicts;
`endif

    b_predictor_assoc dut (
        .clk               (clk),
        .rst               (rst),
        .pred_valid        (pred_valid),
        .pred_pc           (pred_pc),
        .pred_hit          (pred_hit),
        .pred_taken        (pred_taken),
        .pred_target       (pred_target),
        .commit_valid      (commit_valid),
        .commit_pc         (commit_pc),
        .commit_taken      (commit_taken),
        .commit_target     (commit_target),
        .commit_mispredict (commit_mispredict)
`ifdef B_PREDICTOR_STATS_EN
        ,
        .stat_commits      (stat_commits),
        .stat_mispredicts  (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [33:0] exp_q[$];
    logic [63:0] stat_q[$];

    // Reference model: histories as plain integers, BTB sets as way arrays with an MRU-first recency list.
    int          m_spec [64];
    int          m_comm [64];
    int          m_pht  [16];
    bit          m_v    [16][4];
    logic [31:0] m_tag  [16][4];
    logic [31:0] m_tgt  [16][4];
    int          m_ord  [16][4];
    int          m_commits;
    int          m_misp;

    task automatic m_reset();
        for (int i = 0; i < 64; i++) begin m_spec[i] = 0; m_comm[i] = 0; end
        for (int i = 0; i < 16; i++) m_pht[i] = 1;
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 4; w++) begin
                m_v[s][w] = 0; m_tag[s][w] = 0; m_tgt[s][w] = 0; m_ord[s][w] = w;
            end
        m_commits = 0;
        m_misp    = 0;
    endtask

    task automatic m_touch(input int s, input int w);
        int p = 0;
        for (int k = 0; k < 4; k++) if (m_ord[s][k] == w) p = k;
        for (int k = p; k > 0; k--) m_ord[s][k] = m_ord[s][k-1];
        m_ord[s][0] = w;
    endtask

    task automatic m_lookup(input logic [31:0] pc, output bit hit, output int way);
        int s = int'((pc >> 2) % 16);
        hit = 0;
        way = 0;
        for (int w = 0; w < 4; w++)
            if (m_v[s][w] && m_tag[s][w] == (pc >> 6)) begin hit = 1; way = w; end
    endtask

    task automatic cycle(input bit pv, input logic [31:0] ppc, input bit cv, input logic [31:0] cpc,
                         input bit ct, input logic [31:0] ctgt, input bit cm);
        bit          ph, ptk, ch;
        int          pw, cw, h, c, pi, ci;
        int          ps = int'((ppc >> 2) % 16);
        int          cs = -1;
        logic [31:0] ptg;
        @(posedge clk);
        #1;
        pred_valid = pv; pred_pc = ppc;
        commit_valid = cv; commit_pc = cpc; commit_taken = ct;
        commit_target = ctgt; commit_mispredict = cm;
        m_lookup(ppc, ph, pw);
        pi  = int'((ppc >> 2) % 64);
        h   = m_spec[pi];
        ptk = ph && (m_pht[h] >= 2);
        ptg = ph ? m_tgt[ps][pw] : 32'h0;
        if (pv) exp_q.push_back({ph, ptk, ptg});
        stat_q.push_back({32'(m_commits), 32'(m_misp)});
        if (pv && ph) m_spec[pi] = (h * 2 + (ptk ? 1 : 0)) % 16;
        if (cv) begin
            ci = int'((cpc >> 2) % 64);
            c  = m_comm[ci];
            if (ct) begin if (m_pht[c] < 3) m_pht[c]++; end
            else if (m_pht[c] > 0) m_pht[c]--;
            m_comm[ci] = (c * 2 + (ct ? 1 : 0)) % 16;
            m_commits++;
            if (cm) begin
                m_misp++;
                for (int i = 0; i < 64; i++) m_spec[i] = m_comm[i];
            end
            if (ct) begin
                cs = int'((cpc >> 2) % 16);
                m_lookup(cpc, ch, cw);
                if (!ch) begin
                    cw = -1;
                    for (int w = 0; w < 4; w++) if (!m_v[cs][w] && cw < 0) cw = w;
                    if (cw < 0) cw = m_ord[cs][3];
                end
                m_v[cs][cw] = 1; m_tag[cs][cw] = cpc >> 6; m_tgt[cs][cw] = ctgt;
                m_touch(cs, cw);
            end
        end
        if (pv && ph && cs != ps) m_touch(ps, pw);
    endtask

    task automatic pred(input logic [31:0] pc);
        cycle(1, pc, 0, 32'h0, 0, 32'h0, 0);
    endtask

    task automatic commit(input logic [31:0] pc, input bit t, input logic [31:0] tgt, input bit m);
        cycle(0, 32'h0, 1, pc, t, tgt, m);
    endtask

    // Reset asserted mid-traffic with a live commit; outputs must read as fully reset at once.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
        pred_valid = 1; pred_pc = 32'h100;
        commit_valid = 1; commit_pc = 32'h100; commit_taken = 1;
        commit_target = 32'h300; commit_mispredict = 1;
        exp_q.push_back({1'b0, 1'b0, 32'h0});
        stat_q.push_back(64'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        pred_valid = 0; commit_valid = 0; commit_mispredict = 0;
    endtask

    function automatic logic [31:0] rpc();
        return (32'($urandom_range(0, 6)) << 6) | (32'($urandom_range(0, 2)) << 2);
    endfunction

    always @(negedge clk) begin
        logic [33:0] e;
        logic [63:0] st;
        if (pred_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pred_unexpected: pc=%h no expectation queued", pred_pc);
            end else begin
                e = exp_q.pop_front();
                if ({pred_hit, pred_taken, pred_target} !== e) begin
                    bad++;
                    $display("FAIL pred pc=%h: got hit=%b taken=%b target=%h, want hit=%b taken=%b target=%h",
                             pred_pc, pred_hit, pred_taken, pred_target, e[33], e[32], e[31:0]);
                end
            end
        end
        if (stat_q.size() != 0) begin
            st = stat_q.pop_front();
`ifdef B_PREDICTOR_STATS_EN
            total++;
            if ({stat_commits, stat_mispredicts} !== st) begin
                bad++;
                $display("FAIL stats: got commits=%0d mispredicts=%0d, want commits=%0d mispredicts=%0d",
                         stat_commits, stat_mispredicts, st[63:32], st[31:0]);
            end
`endif
        end
    end

    initial begin
        rst = 1'b0;
        pred_valid = 0; pred_pc = 0;
        commit_valid = 0; commit_pc = 0; commit_taken = 0;
        commit_target = 0; commit_mispredict = 0;
        m_reset();
        #23 rst = 1'b1;

        pred(32'h100);
        commit(32'h100, 1, 32'h200, 0);
        pred(32'h100);
        for (int i = 0; i < 4; i++) commit(32'h100, 1, 32'h200, 0);
        pred(32'h100);
        pred(32'h104);

        commit(32'h040, 1, 32'h1000, 0);
        commit(32'h440, 1, 32'h1400, 0);
        commit(32'h840, 1, 32'h1800, 0);
        commit(32'hC40, 1, 32'h1C00, 0);
        pred(32'h040);
        commit(32'h1040, 1, 32'h2000, 0);
        pred(32'h440);
        pred(32'h040);
        pred(32'h1040);
        pred(32'h840);

        pred(32'h100);
        pred(32'h100);
        pred(32'h100);
        cycle(1, 32'h100, 1, 32'h180, 0, 32'h0, 1);
        pred(32'h100);
        cycle(1, 32'h100, 1, 32'h100, 1, 32'h2220, 0);
        pred(32'h100);

        for (int i = 0; i < 10; i++)
            commit(32'h500 + 32'(i) * 4, 1, 32'h800, (i % 4) == 1);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cycle($urandom_range(0, 3) != 0, rpc(), $urandom_range(0, 1) == 1, rpc(),
                  $urandom_range(0, 9) < 6, $urandom() & 32'hFFFF_FFFC, $urandom_range(0, 99) < 15);
        end

        @(posedge clk);
        #1;
        pred_valid = 0; commit_valid = 0; commit_mispredict = 0;
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending predictions, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
